// File: rtl/adder_seq_ctrl.sv
// Chunk-serial W=N*K adder reusing one N-bit ripple slice, LS chunk first.
// Define ADDSEQ_SUB_EN to add the sub port (a-b via ~b and carry-in 1).
module adder_N #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_s,
    output logic         o_cout
);
    logic [N:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar g = 0; g < N; g++) begin : g_fa
        assign o_s[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
        assign w_c[g+1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_cout = w_c[N];
endmodule

module adder_seq_ctrl #(
    parameter  int N  = 4,
    parameter  int K  = 2,
    localparam int W  = N * K,
    localparam int CW = (K > 1) ? $clog2(K) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic          cin,
`ifdef ADDSEQ_SUB_EN
    input  logic          sub,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  sum,
    output logic          cout,
    output logic          busy,
    output logic [CW-1:0] chunk_idx
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(K - 1);

    state_t       r_state;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic         r_carry;

    logic [N-1:0] w_a_chunk;
    logic [N-1:0] w_b_chunk;
    logic [N-1:0] w_s;
    logic         w_co;

    assign w_a_chunk = r_a[chunk_idx*N +: N];
    assign w_b_chunk = r_b[chunk_idx*N +: N];

    adder_N #(.N(N)) u_slice (
        .i_a   (w_a_chunk),
        .i_b   (w_b_chunk),
        .i_cin (r_carry),
        .o_s   (w_s),
        .o_cout(w_co)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_carry   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            chunk_idx <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a       <= a;
`ifdef ADDSEQ_SUB_EN
                        r_b       <= sub ? ~b : b;
                        r_carry   <= sub ? 1'b1 : cin;
`else
                        r_b       <= b;
                        r_carry   <= cin;
`endif
                        chunk_idx <= '0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum[chunk_idx*N +: N] <= w_s;
                    r_carry               <= w_co;
                    if (chunk_idx == LAST) begin
                        cout      <= w_co;
                        chunk_idx <= '0;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        chunk_idx <= chunk_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    // Result is held for as long as the consumer stalls.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Randomized bench for adder_seq_ctrl at (N,K) = (4,2), (3,3), (8,1).
// Results checked against a plain-arithmetic model; ADDSEQ_SUB_EN aware.
module tb_adder_seq_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       out_ready = 1'b0;
    logic       cin = 1'b0;
    logic       sub_i = 1'b0;
    logic       iv0 = 1'b0, iv1 = 1'b0, iv2 = 1'b0;
    logic [7:0] a0 = '0, b0 = '0;
    logic [8:0] a1 = '0, b1 = '0;

    logic       in_ready0, out_valid0, cout0, busy0;
    logic [7:0] sum0;
    logic [0:0] idx0;
    logic       in_ready1, out_valid1, cout1, busy1;
    logic [8:0] sum1;
    logic [1:0] idx1;
    logic       in_ready2, out_valid2, cout2, busy2;
    logic [7:0] sum2;
    logic [0:0] idx2;

    int tests = 0;
    int fails = 0;

    adder_seq_ctrl #(.N(4), .K(2)) dut0 (
        .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(in_ready0),
        .a(a0), .b(b0), .cin(cin),
`ifdef ADDSEQ_SUB_EN
        .sub(sub_i),
`endif
        .out_valid(out_valid0), .out_ready(out_ready), .sum(sum0),
        .cout(cout0), .busy(busy0), .chunk_idx(idx0)
    );

    adder_seq_ctrl #(.N(3), .K(3)) dut1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin),
`ifdef ADDSEQ_SUB_EN
        .sub(sub_i),
`endif
        .out_valid(out_valid1), .out_ready(out_ready), .sum(sum1),
        .cout(cout1), .busy(busy1), .chunk_idx(idx1)
    );

    adder_seq_ctrl #(.N(8), .K(1)) dut2 (
        .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(in_ready2),
        .a(a0), .b(b0), .cin(cin),
`ifdef ADDSEQ_SUB_EN
        .sub(sub_i),
`endif
        .out_valid(out_valid2), .out_ready(out_ready), .sum(sum2),
        .cout(cout2), .busy(busy2), .chunk_idx(idx2)
    );

    // {cout,sum} for a W-bit operation, as plain integer arithmetic.
    function automatic longint unsigned model(input int w,
                                              input longint unsigned a,
                                              input longint unsigned b,
                                              input bit c, input bit s);
        longint unsigned m;
        longint unsigned bb;
        bit cc;
        m  = (64'd1 << w) - 1;
        bb = s ? (~b & m) : (b & m);
        cc = s ? 1'b1 : c;
        return ((a & m) + bb + cc) & ((64'd1 << (w + 1)) - 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op0(input logic [7:0] a, input logic [7:0] b,
                          input logic c, output logic [8:0] r,
                          output int lat, output bit to);
        int n;
        to = 1'b0;
        n = 0;
        while (!in_ready0 && n < 20) begin
            step();
            n++;
        end
        if (!in_ready0) to = 1'b1;
        a0 = a; b0 = b; cin = c; iv0 = 1'b1;
        step();
        iv0 = 1'b0;
        lat = 0;
        while (!out_valid0 && lat < 20) begin
            step();
            lat++;
        end
        if (!out_valid0) to = 1'b1;
        r = {cout0, sum0};
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        tests++;
        if ({in_ready0, out_valid0, busy0, cout0, sum0, idx0} !== 13'h1000) begin
            fails++;
            $display("FAIL reset_dut0 got=%h want=1000",
                     {in_ready0, out_valid0, busy0, cout0, sum0, idx0});
        end
        tests++;
        if ({in_ready1, out_valid1, busy1, cout1, sum1, idx1} !== 15'h4000) begin
            fails++;
            $display("FAIL reset_dut1 got=%h want=4000",
                     {in_ready1, out_valid1, busy1, cout1, sum1, idx1});
        end
        tests++;
        if ({in_ready2, out_valid2, busy2, cout2, sum2, idx2} !== 13'h1000) begin
            fails++;
            $display("FAIL reset_dut2 got=%h want=1000",
                     {in_ready2, out_valid2, busy2, cout2, sum2, idx2});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [8:0] r;
        int lat;
        bit to;
        do_op0(8'h3C, 8'h5A, 1'b0, r, lat, to);
        tests++;
        if (to || r !== 9'h096) begin
            fails++;
            $display("FAIL basic_3c_5a got=%h want=096 timeout=%0d", r, to);
        end
        tests++;
        if (lat !== 2) begin
            fails++;
            $display("FAIL basic_latency got=%0d want=2", lat);
        end
    endtask

    task automatic test_carry();
        logic [8:0] r;
        int lat;
        bit to;
        do_op0(8'hFF, 8'h01, 1'b0, r, lat, to);
        tests++;
        if (to || r !== 9'h100) begin
            fails++;
            $display("FAIL carry_ff_01 got=%h want=100", r);
        end
        do_op0(8'hFF, 8'hFF, 1'b1, r, lat, to);
        tests++;
        if (to || r !== 9'h1FF) begin
            fails++;
            $display("FAIL carry_ff_ff_c1 got=%h want=1ff", r);
        end
    endtask

    task automatic test_backpressure();
        int n;
        a0 = 8'h12; b0 = 8'h34; cin = 1'b1; iv0 = 1'b1;
        step();
        iv0 = 1'b0;
        tests++;
        if (busy0 !== 1'b1 || idx0 !== 1'b0 || in_ready0 !== 1'b0) begin
            fails++;
            $display("FAIL bp_run_entry busy=%b idx=%b rdy=%b want 1 0 0",
                     busy0, idx0, in_ready0);
        end
        // Operand changes after accept must not disturb the result.
        a0 = 8'hAA; b0 = 8'h55; cin = 1'b0;
        n = 0;
        while (!out_valid0 && n < 20) begin
            step();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            a0 = 8'($urandom); b0 = 8'($urandom); iv0 = i[0];
            step();
            tests++;
            if ({out_valid0, in_ready0, busy0, cout0, sum0} !== 12'h847) begin
                fails++;
                $display("FAIL bp_hold_%0d got=%h want=847", i,
                         {out_valid0, in_ready0, busy0, cout0, sum0});
            end
        end
        iv0 = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        tests++;
        if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
            fails++;
            $display("FAIL bp_release rdy=%b vld=%b want 1 0", in_ready0, out_valid0);
        end
        step();
        tests++;
        if (busy0 !== 1'b0 || in_ready0 !== 1'b1) begin
            fails++;
            $display("FAIL bp_no_spurious busy=%b rdy=%b want 0 1", busy0, in_ready0);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [8:0] r;
        int lat;
        bit to;
        a0 = 8'h77; b0 = 8'h11; cin = 1'b0; iv0 = 1'b1;
        step();
        iv0 = 1'b0;
        step();
        tests++;
        if (idx0 !== 1'b1 || busy0 !== 1'b1) begin
            fails++;
            $display("FAIL rst_run_idx idx=%b busy=%b want 1 1", idx0, busy0);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++;
        if ({in_ready0, out_valid0, busy0, sum0} !== 11'h400) begin
            fails++;
            $display("FAIL rst_run_state got=%h want=400",
                     {in_ready0, out_valid0, busy0, sum0});
        end
        step();
        step();
        step();
        tests++;
        if (out_valid0 !== 1'b0) begin
            fails++;
            $display("FAIL rst_run_no_result vld=%b want 0", out_valid0);
        end
        do_op0(8'h01, 8'h02, 1'b0, r, lat, to);
        tests++;
        if (to || r !== 9'h003) begin
            fails++;
            $display("FAIL rst_run_next_op got=%h want=003", r);
        end
    endtask

    task automatic test_sub();
`ifdef ADDSEQ_SUB_EN
        logic [8:0] r;
        int lat;
        bit to;
        sub_i = 1'b1;
        do_op0(8'h10, 8'h01, 1'b0, r, lat, to);
        tests++;
        if (to || r !== 9'h10F) begin
            fails++;
            $display("FAIL sub_10_01 got=%h want=10f", r);
        end
        do_op0(8'h01, 8'h02, 1'b1, r, lat, to);
        tests++;
        if (to || r !== 9'h0FF) begin
            fails++;
            $display("FAIL sub_01_02 got=%h want=0ff", r);
        end
        sub_i = 1'b0;
`endif
    endtask

    task automatic test_random(input int nops);
        logic [7:0] ea0, eb0;
        logic [8:0] ea1, eb1;
        bit ec, es;
        longint unsigned e0, e1, e2;
        int n;
        for (int k = 0; k < nops; k++) begin
            n = 0;
            while (!(in_ready0 && in_ready1 && in_ready2) && n < 20) begin
                step();
                n++;
            end
            ea0 = 8'($urandom); eb0 = 8'($urandom);
            ea1 = 9'($urandom); eb1 = 9'($urandom);
            ec = 1'($urandom);
`ifdef ADDSEQ_SUB_EN
            es = 1'($urandom);
`else
            es = 1'b0;
`endif
            a0 = ea0; b0 = eb0; a1 = ea1; b1 = eb1; cin = ec; sub_i = es;
            iv0 = 1'b1; iv1 = 1'b1; iv2 = 1'b1;
            step();
            iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
            a0 = 8'($urandom); b0 = 8'($urandom);
            a1 = 9'($urandom); b1 = 9'($urandom);
            cin = 1'($urandom); sub_i = 1'b0;
            n = 0;
            while (!(out_valid0 && out_valid1 && out_valid2) && n < 20) begin
                step();
                n++;
            end
            repeat ($urandom_range(0, 3)) step();
            e0 = model(8, 64'(ea0), 64'(eb0), ec, es);
            e1 = model(9, 64'(ea1), 64'(eb1), ec, es);
            e2 = e0;
            tests++;
            if (out_valid0 !== 1'b1 || 64'({cout0, sum0}) !== e0) begin
                fails++;
                $display("FAIL rnd_n4k2 op=%0d got=%h want=%h vld=%b",
                         k, {cout0, sum0}, e0, out_valid0);
            end
            tests++;
            if (out_valid1 !== 1'b1 || 64'({cout1, sum1}) !== e1) begin
                fails++;
                $display("FAIL rnd_n3k3 op=%0d got=%h want=%h vld=%b",
                         k, {cout1, sum1}, e1, out_valid1);
            end
            tests++;
            if (out_valid2 !== 1'b1 || 64'({cout2, sum2}) !== e2) begin
                fails++;
                $display("FAIL rnd_n8k1 op=%0d got=%h want=%h vld=%b",
                         k, {cout2, sum2}, e2, out_valid2);
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_reset_mid_run();
        test_sub();
        test_random(600);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
